// File: rtl/bo_datapath.sv
// Operative block: X/H/S registers with an add/multiply ALU fed by two operand muxes.
// Latency: loads land one clock after the enabling edge; done follows LS by one clock.
// Backpressure: none; every enable is acted on at the edge where it is sampled.
module bo_datapath #(
    parameter int WIDTH = 16,
    parameter int C0    = 3,
    parameter int C1    = 5,
    parameter int C2    = 2,
    parameter int C3    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_in,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic             Hula,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] h_out,
    output logic             done,
    output logic             ovf
);

    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   h_q;
    logic [WIDTH-1:0]   s_q;
    logic               done_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   const_op;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   result;
    logic               ovf_term;
    logic               ovf_set;

    // Constant and operand selection from the current (pre-edge) register values
    always_comb begin
        const_op = WIDTH'(C0);
        case (M0)
            2'd0:    const_op = WIDTH'(C0);
            2'd1:    const_op = WIDTH'(C1);
            2'd2:    const_op = WIDTH'(C2);
            default: const_op = WIDTH'(C3);
        endcase

        op_a = '0;
        case (M1)
            2'd0:    op_a = s_q;
            2'd1:    op_a = x_q;
            2'd2:    op_a = h_q;
            default: op_a = '0;
        endcase

        op_b = const_op;
        case (M2)
            2'd0:    op_b = const_op;
            2'd1:    op_b = h_q;
            2'd2:    op_b = s_q;
            default: op_b = x_q;
        endcase
    end

    // Unsigned ALU: full-width sum/product so the dropped high bits can flag overflow
    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        prod     = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        result   = Hula ? prod[WIDTH-1:0] : sum[WIDTH-1:0];
        ovf_term = Hula ? (|prod[2*WIDTH-1:WIDTH]) : sum[WIDTH];
        // Overflow only matters when the result is actually stored somewhere
        ovf_set  = (LH | LS) & ovf_term;
    end

    // Register file, done pulse and sticky overflow; reset beats every enable
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            h_q    <= '0;
            s_q    <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (LX) x_q <= x_in;
            if (LH) h_q <= result;
            if (LS) s_q <= result;
            done_q <= LS;
            // A fresh overflow outranks the clear that a new sample load implies
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (LX)
                ovf_q <= 1'b0;
        end
    end

    assign s_out = s_q;
    assign h_out = h_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule
